// File: rtl/tgco_pkg.sv
// Shared definitions for the priority-code decoder: FSM encoding, code
// constants, grant width and the code-to-line decode helper.
package tgco_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_MAX  = 3'd4;
  localparam int         ONEHOT_W  = 4;

  // Codes 1..4 map to line 0..3; anything else selects no line.
  function automatic logic [ONEHOT_W-1:0] code_to_onehot(input logic [2:0] code);
    logic [ONEHOT_W-1:0] oh;
    oh = '0;
    case (code)
      3'd1:    oh = 4'b0001;
      3'd2:    oh = 4'b0010;
      3'd3:    oh = 4'b0100;
      3'd4:    oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/tgco_timeout_counter.sv
// Grant-age timer. Loaded with TIMEOUT-1 on clear and counted down while
// enabled; expire is the terminal-count compare qualified by enable, so it
// fires on the TIMEOUT-th enabled cycle after a clear.
module tgco_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  // Down-counter: reload on clear, decrement while enabled, hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= LOAD_VAL;
    end else if (enable && (cnt_q != 8'd0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign expire = enable && (cnt_q == 8'd0);

endmodule

// File: rtl/priority_decoder_tgco.sv
// Registered priority-code decoder with valid/ack grant handshake.
// Optional grant timeout: define PRIORITY_DECODER_TGCO_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for a valid nonzero code
//   GRANT | one-hot line held, waiting for ack (or timeout)
//   DONE  | one-cycle completion, done pulse, new codes dropped
module priority_decoder_tgco
  import tgco_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          code_in,
  input  logic                code_valid,
  input  logic                ack,
  output logic [ONEHOT_W-1:0] onehot_out,
  output logic                busy,
  output logic                done,
  output logic                err_code,
  output logic                dropped,
  output logic                timeout,
  output logic [CNT_W-1:0]    grant_cnt
);

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  state_t              state_q, state_d;
  logic [2:0]          code_q, code_d;
  logic [ONEHOT_W-1:0] onehot_d;
  logic                done_d, err_d, drop_d, to_d, cnt_inc;
  logic                tmr_expire;

`ifdef PRIORITY_DECODER_TGCO_TIMEOUT_EN
  logic tmr_clear, tmr_en;

  assign tmr_clear = (state_q == IDLE) && (state_d == GRANT);
  assign tmr_en    = (state_q == GRANT);

  tgco_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    onehot_d = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    drop_d   = 1'b0;
    to_d     = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (code_valid) begin
          if ((code_in != CODE_NONE) && (code_in <= CODE_MAX)) begin
            state_d  = GRANT;
            code_d   = code_in;
            onehot_d = code_to_onehot(code_in);
            cnt_inc  = 1'b1;
          end else if (code_in > CODE_MAX) begin
            err_d = 1'b1;
          end
        end
      end
      GRANT: begin
        // ack on the expiry cycle takes priority over the timeout exit
        if (ack) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (tmr_expire) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          onehot_d = code_to_onehot(code_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Any nonzero code while busy is discarded, illegal ones included.
    if ((state_q != IDLE) && code_valid && (code_in != CODE_NONE)) begin
      drop_d = 1'b1;
    end
  end

  // State, latched code and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= CODE_NONE;
      onehot_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 1'b0;
      dropped    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      onehot_out <= onehot_d;
      busy       <= (state_d != IDLE);
      done       <= done_d;
      err_code   <= err_d;
      dropped    <= drop_d;
      timeout    <= to_d;
    end
  end

  // Saturating grant counter, bumped on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (cnt_inc && (grant_cnt != {CNT_W{1'b1}})) begin
      grant_cnt <= grant_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_priority_decoder_tgco.sv
// Directed bench for priority_decoder_tgco: a per-cycle vector table for the
// handshake basics plus hand-written timeout, saturation and reset sequences.
module tb_priority_decoder_tgco;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code_in;
  logic       code_valid, ack;
  logic [3:0] onehot_out;
  logic       busy, done, err_code, dropped, timeout;
  logic [7:0] grant_cnt;

  logic [2:0] code_in2;
  logic       code_valid2, ack2;
  logic [3:0] onehot_out2;
  logic       busy2, done2, err_code2, dropped2, timeout2;
  logic [1:0] grant_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  priority_decoder_tgco #(.CNT_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid), .ack(ack),
    .onehot_out(onehot_out), .busy(busy), .done(done), .err_code(err_code),
    .dropped(dropped), .timeout(timeout), .grant_cnt(grant_cnt)
  );

  priority_decoder_tgco #(.CNT_W(2), .TIMEOUT(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .code_in(code_in2), .code_valid(code_valid2), .ack(ack2),
    .onehot_out(onehot_out2), .busy(busy2), .done(done2), .err_code(err_code2),
    .dropped(dropped2), .timeout(timeout2), .grant_cnt(grant_cnt2)
  );

  typedef struct {
    logic [2:0] code;
    logic       valid;
    logic       ack;
    logic [3:0] oh;
    logic       busy;
    logic       done;
    logic       err;
    logic       drop;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic v, input logic a);
    @(negedge clk);
    code_in    = c;
    code_valid = v;
    ack        = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // code, valid, ack | onehot, busy, done, err, drop, cnt (after the edge)
    vecs[0]  = '{3'd3, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[1]  = '{3'd0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[2]  = '{3'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[3]  = '{3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[4]  = '{3'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{3'd6, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[6]  = '{3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{3'd1, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[8]  = '{3'd4, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{3'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[10] = '{3'd4, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[11] = '{3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[13] = '{3'd2, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[14] = '{3'd7, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3};
    vecs[15] = '{3'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[16] = '{3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};

    rst_n = 1'b0;
    code_in = 3'd0; code_valid = 1'b0; ack = 1'b0;
    code_in2 = 3'd0; code_valid2 = 1'b0; ack2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset onehot", 32'(onehot_out), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset flags", 32'({done, err_code, dropped, timeout}), 32'h0);
    chk("reset cnt", 32'(grant_cnt), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].code, vecs[i].valid, vecs[i].ack);
      tick();
      chk($sformatf("v%0d onehot", i), 32'(onehot_out), 32'(vecs[i].oh));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(vecs[i].err));
      chk($sformatf("v%0d dropped", i), 32'(dropped), 32'(vecs[i].drop));
      chk($sformatf("v%0d timeout", i), 32'(timeout), 32'h0);
      chk($sformatf("v%0d grant_cnt", i), 32'(grant_cnt), 32'(vecs[i].cnt));
    end

`ifdef PRIORITY_DECODER_TGCO_TIMEOUT_EN
    // No ack: line held 4 cycles, then abandoned with a timeout pulse.
    drive(3'd2, 1'b1, 1'b0);
    tick();
    chk("to capture onehot", 32'(onehot_out), 32'h2);
    drive(3'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick(); else tick();
      chk($sformatf("to hold%0d onehot", k), 32'(onehot_out), 32'h2);
      chk($sformatf("to hold%0d timeout", k), 32'(timeout), 32'h0);
    end
    tick();
    chk("to expire onehot", 32'(onehot_out), 32'h0);
    chk("to expire timeout", 32'(timeout), 32'h1);
    chk("to expire busy", 32'(busy), 32'h0);
    chk("to expire done", 32'(done), 32'h0);
    tick();
    chk("to after timeout", 32'(timeout), 32'h0);
    // Ack on the expiry cycle wins.
    drive(3'd2, 1'b1, 1'b0);
    tick();
    drive(3'd0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("to race onehot", 32'(onehot_out), 32'h2);
    drive(3'd0, 1'b0, 1'b1);
    tick();
    chk("to race done", 32'(done), 32'h1);
    chk("to race timeout", 32'(timeout), 32'h0);
    chk("to race busy", 32'(busy), 32'h1);
    drive(3'd0, 1'b0, 1'b0);
    tick();
    chk("to race idle", 32'(busy), 32'h0);
`else
    // Without the timeout the grant waits on ack indefinitely.
    drive(3'd2, 1'b1, 1'b0);
    tick();
    drive(3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("hold%0d onehot", k), 32'(onehot_out), 32'h2);
      chk($sformatf("hold%0d timeout", k), 32'(timeout), 32'h0);
    end
    drive(3'd0, 1'b0, 1'b1);
    tick();
    chk("hold done", 32'(done), 32'h1);
    drive(3'd0, 1'b0, 1'b0);
    tick();
    chk("hold idle", 32'(busy), 32'h0);
`endif

    // Two-bit counter saturates at 3.
    for (int g = 1; g <= 5; g++) begin
      @(negedge clk); code_in2 = 3'd1; code_valid2 = 1'b1; ack2 = 1'b0;
      tick();
      chk($sformatf("sat grant%0d onehot", g), 32'(onehot_out2), 32'h1);
      chk($sformatf("sat grant%0d cnt", g), 32'(grant_cnt2), (g > 3) ? 32'd3 : 32'(g));
      @(negedge clk); code_valid2 = 1'b0; ack2 = 1'b1;
      tick();
      @(negedge clk); ack2 = 1'b0;
      tick();
    end

    // Asynchronous reset in the middle of a grant.
    drive(3'd3, 1'b1, 1'b0);
    tick();
    drive(3'd0, 1'b0, 1'b0);
    chk("pre-reset onehot", 32'(onehot_out), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset onehot", 32'(onehot_out), 32'h0);
    chk("async reset cnt", 32'(grant_cnt), 32'h0);
    chk("async reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd4, 1'b1, 1'b0);
    tick();
    chk("post-reset onehot", 32'(onehot_out), 32'h8);
    chk("post-reset cnt", 32'(grant_cnt), 32'h1);
    drive(3'd0, 1'b0, 1'b1);
    tick();
    chk("post-reset done", 32'(done), 32'h1);
    drive(3'd0, 1'b0, 1'b0);
    tick();
    chk("post-reset idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
